motoro3_bridge_driver: RTL and testbench
========================================

# motoro3_bridge_driver

Three-phase MOS bridge gate sequencer downstream of the PWM generator. Consumes the chopped `pwm` stream and the commutation step index. Drives the six high/low-side gate enables using the six-step commutation table. Inserts a programmable all-off dead time at every step change and latches a sticky fault on an illegal step.

## Interface
Parameters:
- `DEAD_W`, default 8: width of the dead-time count, in clk cycles.

Ports:
- `clk` in 1: 10 MHz system clock. All state updates on the rising edge.
- `nRst` in 1: reset, asynchronous, active-low.
- `pwm` in 1: chopped drive from the PWM generator. It is launched on the falling edge and sampled here on the rising edge.
- `m3cntLast1` in 1: one-cycle step-boundary strobe.
- `m3stepIdx` in 3: commutation step. Values 0..5 are legal; 6 and 7 are illegal.
- `m3r_deadTime` in DEAD_W: dead time in cycles. A value of 0 is treated as 1.
- `m3r_enable` in 1: bridge enable.
- `m3r_brake` in 1: brake request. Only honoured when `MOTORO3_BRAKE_EN` is defined.
- `gateHi` out 3: high-side enables, phase order {C,B,A}.
- `gateLo` out 3: low-side enables, phase order {C,B,A}.
- `drvFault` out 1: sticky illegal-step fault.
- `drvBusy` out 1: high while in DEAD.

## Operation
- FSM states: IDLE, DEAD, DRIVE, FAULT, and BRAKE (macro only). All outputs are registered.
- Reset values:
  - State is IDLE.
  - `gateHi`=0, `gateLo`=0, `drvFault`=0, `drvBusy`=0.
  - Internal `pwmQ`=0, `stepCur`=0, `deadCnt`=0.
- Commutation table. "Hi" is the phase whose high side is gated by `pwmQ`; "Lo" is the phase whose low side is held on for the whole step:

| Step | Hi | Lo |
|---|---|---|
| 0 | A | B |
| 1 | A | C |
| 2 | B | C |
| 3 | B | A |
| 4 | C | A |
| 5 | C | B |

- The third phase is fully off in every step.
- IDLE:
  - All gates off.
  - On `m3r_enable`=1: latch `m3stepIdx` into `stepCur`, load `deadCnt` with max(`m3r_deadTime`,1), go to DEAD.
- DEAD:
  - All gates off, `drvBusy`=1.
  - `deadCnt` decrements each cycle.
  - When `deadCnt`==1, go to DRIVE.
- DRIVE:
  - `gateHi[Hi]` = `pwmQ`, `gateLo[Lo]` = 1, all other gates 0.
  - On `m3cntLast1` with `m3stepIdx` ≠ `stepCur`: latch the new index, reload `deadCnt`, go to DEAD.
  - On `m3cntLast1` with an equal index: stay in DRIVE with no dead time.
- Illegal step:
  - Any latch of `m3stepIdx` ≥ 6 goes to FAULT.
  - In FAULT: all gates off, `drvFault`=1.
  - FAULT is left only when `m3r_enable`=0, which goes to IDLE and clears `drvFault`.
- `m3r_enable`=0 in any state goes to IDLE on the next edge with all gates off. This has priority over everything except reset.
- Simultaneous events:
  - A strobe during DEAD relatches the step and restarts `deadCnt` from the full value.
  - `m3r_enable` falling in the same cycle as a strobe: IDLE wins.
- Invariant: `gateHi[i] & gateLo[i]` is never 1 for any phase, in any cycle.
- Asynchronous reset mid-operation forces all gates off immediately.

## Timing
- `pwm` to `gateHi` latency: `pwmQ` is 1 cycle and the output register is 1 cycle, so 2 rising edges total.
- Strobe sampled at edge N:
  - Gates go all-off from edge N+1.
  - New-step gates appear at edge N+1+D, where D = max(`m3r_deadTime`,1).
- Enable high sampled at edge N: first drive at edge N+1+D.
- `m3r_deadTime` is sampled only at load. Changing it mid-DEAD has no effect on the current dead period.

## Configuration
- `MOTORO3_BRAKE_EN` defined:
  - `m3r_brake`=1 in DRIVE or DEAD reloads `deadCnt`, passes through DEAD, then enters BRAKE.
  - BRAKE: `gateLo`=3'b111, `gateHi`=0.
  - `m3r_brake`=0 goes BRAKE → DEAD (full dead time) → DRIVE using the current `stepCur`.
  - Enable=0 and fault still take priority over BRAKE.
- `MOTORO3_BRAKE_EN` undefined:
  - `m3r_brake` is ignored.
  - The BRAKE state does not exist.
  - `gateLo` never has more than one bit set.

## Test plan
- Reset → `gateHi`=0, `gateLo`=0, `drvFault`=0. Then enable=1, step=0, deadTime=4, `pwm` held 1 → gates 0 for 4 cycles, then `gateHi`=001 and `gateLo`=010.
- In DRIVE step 0, strobe with step=1, deadTime=3 → 3 all-off cycles, `drvBusy`=1, then `gateHi`=001 and `gateLo`=100. A strobe with step=1 again produces no gap.
- deadTime=0 → exactly 1 all-off cycle. Toggle `pwm` every 5 cycles → `gateHi` toggles 2 edges later; the low-side bit is steady.
- Strobe with step=6 → FAULT, all gates 0, `drvFault`=1 and held. Enable=0 → IDLE with `drvFault`=0.
- Strobe during DEAD (deadTime=8, second strobe at count 3) → the dead time restarts and the total gap is 5+8 cycles. Assert no-overlap across random steps/pwm for 10k cycles.
- With `MOTORO3_BRAKE_EN`: brake=1 in DRIVE → D off cycles, then `gateLo`=111 and `gateHi`=000. Brake=0 → D off cycles, then the previous step resumes. Without the macro, brake has no effect.

Source files
------------

// File: rtl/motoro3_bridge_driver_if.sv
// -----------------------------------------------------------------------------
// motoro3_bridge_driver_if
//   Bundles the PWM/commutation inputs and the gate-drive outputs of the
//   three-phase bridge gate sequencer.
//
//   Parameter:
//     DEAD_W        width of the dead-time count
//   Signals:
//     pwm           chopped drive from the PWM generator
//     m3cntLast1    one-cycle step-boundary strobe
//     m3stepIdx     commutation step (0..5 legal)
//     m3r_deadTime  dead time in clk cycles (0 behaves as 1)
//     m3r_enable    bridge enable
//     m3r_brake     brake request (honoured only with MOTORO3_BRAKE_EN)
//     gateHi/gateLo high/low-side gate enables, phase order {C,B,A}
//     drvFault      sticky illegal-step fault
//     drvBusy       high while the bridge is in dead time
//   Modports:
//     master        the side that drives the controls (PWM block / bench)
//     slave         the gate sequencer itself
// -----------------------------------------------------------------------------
interface motoro3_bridge_driver_if #(
    parameter int DEAD_W = 8
);
    logic              pwm;
    logic              m3cntLast1;
    logic [2:0]        m3stepIdx;
    logic [DEAD_W-1:0] m3r_deadTime;
    logic              m3r_enable;
    logic              m3r_brake;
    logic [2:0]        gateHi;
    logic [2:0]        gateLo;
    logic              drvFault;
    logic              drvBusy;

    modport master (
        output pwm, m3cntLast1, m3stepIdx, m3r_deadTime, m3r_enable, m3r_brake,
        input  gateHi, gateLo, drvFault, drvBusy
    );

    modport slave (
        input  pwm, m3cntLast1, m3stepIdx, m3r_deadTime, m3r_enable, m3r_brake,
        output gateHi, gateLo, drvFault, drvBusy
    );
endinterface

// File: rtl/motoro3_bridge_driver.sv
// -----------------------------------------------------------------------------
// motoro3_bridge_driver
//   Three-phase MOS bridge gate sequencer. Maps the commutation step onto the
//   six gate enables (high side chopped by the registered pwm, low side held
//   on), inserts an all-off dead time at every step change and latches a
//   sticky fault on an illegal step index.
//
//   Ports:
//     clk    system clock, all state on the rising edge
//     nRst   asynchronous active-low reset
//     m3Bus  motoro3_bridge_driver_if.slave (controls in, gate drive out)
//
//   Optional feature:
//     MOTORO3_BRAKE_EN  when defined, m3r_brake routes the bridge through a
//                       dead time into a BRAKE state with all low sides on.
// -----------------------------------------------------------------------------
module motoro3_bridge_driver #(
    parameter int DEAD_W = 8
) (
    input  logic                    clk,
    input  logic                    nRst,
    motoro3_bridge_driver_if.slave  m3Bus
);

`ifdef MOTORO3_BRAKE_EN
    typedef enum logic [2:0] {IDLE, DEAD, DRIVE, FAULT, BRAKE} state_t;
    logic brakePend, brakePendNext;   // current dead period leads into BRAKE
`else
    typedef enum logic [2:0] {IDLE, DEAD, DRIVE, FAULT} state_t;
    logic unusedBrake;
    assign unusedBrake = m3Bus.m3r_brake;
`endif

    state_t            stateReg, stateNext;
    logic              pwmQ;
    logic [2:0]        stepCur, stepNext;
    logic [DEAD_W-1:0] deadCnt, deadNext;
    logic [DEAD_W-1:0] deadLoad;
    logic              stepLegal;
    logic [2:0]        gateHiReg, gateHiNext;
    logic [2:0]        gateLoReg, gateLoNext;
    logic              drvFaultReg, drvFaultNext;
    logic              drvBusyReg, drvBusyNext;

    assign deadLoad  = (m3Bus.m3r_deadTime == '0) ? DEAD_W'(1) : m3Bus.m3r_deadTime;
    assign stepLegal = (m3Bus.m3stepIdx < 3'd6);

    // State and output registers
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            stateReg    <= IDLE;
            pwmQ        <= 1'b0;
            stepCur     <= 3'd0;
            deadCnt     <= '0;
            gateHiReg   <= 3'b000;
            gateLoReg   <= 3'b000;
            drvFaultReg <= 1'b0;
            drvBusyReg  <= 1'b0;
`ifdef MOTORO3_BRAKE_EN
            brakePend   <= 1'b0;
`endif
        end else begin
            stateReg    <= stateNext;
            pwmQ        <= m3Bus.pwm;
            stepCur     <= stepNext;
            deadCnt     <= deadNext;
            gateHiReg   <= gateHiNext;
            gateLoReg   <= gateLoNext;
            drvFaultReg <= drvFaultNext;
            drvBusyReg  <= drvBusyNext;
`ifdef MOTORO3_BRAKE_EN
            brakePend   <= brakePendNext;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = stateReg;
        stepNext  = stepCur;
        deadNext  = deadCnt;
`ifdef MOTORO3_BRAKE_EN
        brakePendNext = brakePend;
`endif
        if (!m3Bus.m3r_enable) begin
            stateNext = IDLE;
`ifdef MOTORO3_BRAKE_EN
            brakePendNext = 1'b0;
`endif
        end else begin
            case (stateReg)
                IDLE: begin
                    stepNext  = m3Bus.m3stepIdx;
                    deadNext  = deadLoad;
                    stateNext = stepLegal ? DEAD : FAULT;
                end
                DEAD: begin
                    if (m3Bus.m3cntLast1) begin
                        // Any strobe relatches and restarts the full dead time
                        stepNext  = m3Bus.m3stepIdx;
                        deadNext  = deadLoad;
                        stateNext = stepLegal ? DEAD : FAULT;
`ifdef MOTORO3_BRAKE_EN
                    end else if (m3Bus.m3r_brake && !brakePend) begin
                        deadNext      = deadLoad;
                        brakePendNext = 1'b1;
`endif
                    end else begin
                        deadNext = deadCnt - DEAD_W'(1);
                        if (deadCnt <= DEAD_W'(1)) begin
`ifdef MOTORO3_BRAKE_EN
                            // Brake dropped mid-dead-time falls back to DRIVE
                            stateNext     = (brakePend && m3Bus.m3r_brake) ? BRAKE : DRIVE;
                            brakePendNext = 1'b0;
`else
                            stateNext = DRIVE;
`endif
                        end
                    end
                end
                DRIVE: begin
                    if (m3Bus.m3cntLast1 && (m3Bus.m3stepIdx != stepCur)) begin
                        stepNext  = m3Bus.m3stepIdx;
                        deadNext  = deadLoad;
                        stateNext = stepLegal ? DEAD : FAULT;
`ifdef MOTORO3_BRAKE_EN
                    end else if (m3Bus.m3r_brake) begin
                        deadNext      = deadLoad;
                        brakePendNext = 1'b1;
                        stateNext     = DEAD;
`endif
                    end
                end
                FAULT: stateNext = FAULT;
`ifdef MOTORO3_BRAKE_EN
                BRAKE: begin
                    if (!m3Bus.m3r_brake) begin
                        deadNext      = deadLoad;
                        brakePendNext = 1'b0;
                        stateNext     = DEAD;
                    end
                end
`endif
                default: stateNext = IDLE;
            endcase
        end
    end

    // Output logic. Outputs follow the current state one edge later, except
    // that a low enable blanks everything on the very next edge.
    always_comb begin
        gateHiNext   = 3'b000;
        gateLoNext   = 3'b000;
        drvFaultNext = 1'b0;
        drvBusyNext  = 1'b0;
        if (m3Bus.m3r_enable) begin
            case (stateReg)
                DEAD:  drvBusyNext  = 1'b1;
                FAULT: drvFaultNext = 1'b1;
                DRIVE: begin
                    // Hi and Lo phases always differ, so no shoot-through
                    case (stepCur)
                        3'd0: begin gateHiNext = {2'b00, pwmQ};       gateLoNext = 3'b010; end
                        3'd1: begin gateHiNext = {2'b00, pwmQ};       gateLoNext = 3'b100; end
                        3'd2: begin gateHiNext = {1'b0, pwmQ, 1'b0};  gateLoNext = 3'b100; end
                        3'd3: begin gateHiNext = {1'b0, pwmQ, 1'b0};  gateLoNext = 3'b001; end
                        3'd4: begin gateHiNext = {pwmQ, 2'b00};       gateLoNext = 3'b001; end
                        3'd5: begin gateHiNext = {pwmQ, 2'b00};       gateLoNext = 3'b010; end
                        default: begin gateHiNext = 3'b000;           gateLoNext = 3'b000; end
                    endcase
                end
`ifdef MOTORO3_BRAKE_EN
                BRAKE: gateLoNext = 3'b111;
`endif
                default: ;
            endcase
        end
    end

    assign m3Bus.gateHi   = gateHiReg;
    assign m3Bus.gateLo   = gateLoReg;
    assign m3Bus.drvFault = drvFaultReg;
    assign m3Bus.drvBusy  = drvBusyReg;

endmodule

// File: tb/tb_motoro3_bridge_driver.sv
`timescale 1ns/1ps
// Bench for motoro3_bridge_driver. Inputs change on the falling edge, outputs
// are observed on the falling edge. Expected words are
// {drvFault, drvBusy, gateLo[2:0], gateHi[2:0]}.
module tb_motoro3_bridge_driver;
    logic clk = 1'b0;
    logic nRst = 1'b0;
    always #50 clk = ~clk;

    motoro3_bridge_driver_if #(.DEAD_W(8)) bus();
    motoro3_bridge_driver #(.DEAD_W(8)) dut (
        .clk   (clk),
        .nRst  (nRst),
        .m3Bus (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] expQ[$];
    string      tagQ[$];

    function automatic logic [7:0] obs();
        return {bus.drvFault, bus.drvBusy, bus.gateLo, bus.gateHi};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] v, input int n, input string tag);
        repeat (n) begin
            expQ.push_back(v);
            tagQ.push_back(tag);
        end
    endtask

    task automatic test_reset();
        logic [7:0] e, o;
        string t;
        int n;
        bus.pwm = 0; bus.m3cntLast1 = 0; bus.m3stepIdx = 0;
        bus.m3r_deadTime = 0; bus.m3r_enable = 0; bus.m3r_brake = 0;
        nRst = 0;
        repeat (3) tick();
        o = obs();
        checks++;
        if (o !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold: got %h expected %h", o, 8'h00);
        end
        nRst = 1;
        push(8'h00, 2, "reset_release");
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic test_enable();
        logic [7:0] e, o;
        string t;
        int n;
        push(8'h00, 1, "en_idle");
        push(8'h40, 4, "en_dead");
        push(8'h11, 3, "en_drive0");
        bus.m3r_enable = 1; bus.m3stepIdx = 0; bus.m3r_deadTime = 4; bus.pwm = 1;
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic test_step_change();
        logic [7:0] e, o;
        string t;
        int n;
        push(8'h11, 1, "sc_strobe");
        push(8'h40, 3, "sc_dead");
        push(8'h21, 3, "sc_drive1");
        push(8'h21, 4, "sc_same_step");
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            case (i)
                0: begin bus.m3cntLast1 = 1; bus.m3stepIdx = 1; bus.m3r_deadTime = 3; end
                1: begin bus.m3cntLast1 = 0; bus.m3r_deadTime = 7; end
                7: bus.m3cntLast1 = 1;
                8: bus.m3cntLast1 = 0;
                default: ;
            endcase
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic test_deadzero_pwm();
        logic [7:0] e, o;
        string t;
        int n;
        logic p;
        push(8'h21, 1, "dz_strobe");
        push(8'h40, 1, "dz_dead1");
        push(8'h22, 2, "dz_drive2");
        p = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(p ? 8'h22 : 8'h20, 1, "pwm_lag");
            p = ~p;
            push(p ? 8'h22 : 8'h20, 4, "pwm_follow");
        end
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            if (i == 0) begin
                bus.m3cntLast1 = 1; bus.m3stepIdx = 2; bus.m3r_deadTime = 0;
            end else if (i == 1) begin
                bus.m3cntLast1 = 0;
            end else if (i >= 4 && (i - 4) % 5 == 0) begin
                bus.pwm = ~bus.pwm;
            end
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic test_fault();
        logic [7:0] e, o;
        string t;
        int n;
        push(8'h22, 1, "flt_strobe");
        push(8'h80, 5, "flt_sticky");
        push(8'h00, 3, "flt_clear");
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            case (i)
                0: begin bus.m3cntLast1 = 1; bus.m3stepIdx = 6; end
                1: begin bus.m3cntLast1 = 0; bus.m3stepIdx = 0; end
                6: bus.m3r_enable = 0;
                default: ;
            endcase
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic test_dead_restart();
        logic [7:0] e, o;
        string t;
        int n;
        push(8'h00, 1, "dr_idle");
        push(8'h40, 2, "dr_dead");
        push(8'h0A, 2, "dr_drive3");
        push(8'h0A, 1, "dr_strobe1");
        push(8'h40, 4, "dr_dead_a");
        push(8'h40, 1, "dr_strobe2");
        push(8'h40, 8, "dr_dead_restart");
        push(8'h14, 3, "dr_drive5");
        push(8'h00, 3, "dr_disable_wins");
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            case (i)
                0:  begin bus.m3r_enable = 1; bus.m3stepIdx = 3; bus.m3r_deadTime = 2; bus.pwm = 1; end
                5:  begin bus.m3cntLast1 = 1; bus.m3stepIdx = 4; bus.m3r_deadTime = 8; end
                6:  bus.m3cntLast1 = 0;
                10: begin bus.m3cntLast1 = 1; bus.m3stepIdx = 5; end
                11: bus.m3cntLast1 = 0;
                22: begin bus.m3r_enable = 0; bus.m3cntLast1 = 1; bus.m3stepIdx = 0; end
                23: bus.m3cntLast1 = 0;
                default: ;
            endcase
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic test_brake();
        logic [7:0] e, o;
        string t;
        int n;
        push(8'h00, 1, "bk_idle");
        push(8'h40, 3, "bk_dead0");
        push(8'h11, 2, "bk_drive0");
`ifdef MOTORO3_BRAKE_EN
        push(8'h11, 1, "bk_request");
        push(8'h40, 3, "bk_dead_in");
        push(8'h38, 3, "bk_braking");
        push(8'h38, 1, "bk_release");
        push(8'h40, 3, "bk_dead_out");
        push(8'h11, 2, "bk_resume");
`else
        push(8'h11, 6, "bk_ignored");
`endif
        n = expQ.size();
        for (int i = 0; i < n; i++) begin
            case (i)
                0:  begin bus.m3r_enable = 1; bus.m3stepIdx = 0; bus.m3r_deadTime = 3; bus.pwm = 1; bus.m3r_brake = 0; end
                6:  bus.m3r_brake = 1;
                13: bus.m3r_brake = 0;
                default: ;
            endcase
            tick();
            e = expQ.pop_front(); t = tagQ.pop_front(); o = obs();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", t, o, e);
            end
        end
        bus.m3r_brake = 0;
        bus.m3r_enable = 0;
        tick();
    endtask

    task automatic test_async_reset();
        logic [7:0] o;
        bus.m3r_enable = 1; bus.m3stepIdx = 0; bus.m3r_deadTime = 1; bus.pwm = 1;
        repeat (4) tick();
        o = obs();
        checks++;
        if (o !== 8'h11) begin
            failures++;
            $display("FAIL ar_before: got %h expected %h", o, 8'h11);
        end
        #10 nRst = 0;
        #1 o = obs();
        checks++;
        if (o !== 8'h00) begin
            failures++;
            $display("FAIL ar_immediate: got %h expected %h", o, 8'h00);
        end
        bus.m3r_enable = 0;
        tick();
        nRst = 1;
        tick();
    endtask

    task automatic test_random_overlap();
        logic bad;
        int badCount = 0;
        for (int i = 0; i < 10000; i++) begin
            bus.m3cntLast1   = ($urandom_range(0, 7) == 0);
            bus.m3stepIdx    = 3'($urandom_range(0, 5));
            bus.pwm          = 1'($urandom_range(0, 1));
            bus.m3r_deadTime = 8'($urandom_range(0, 3));
            bus.m3r_enable   = ($urandom_range(0, 99) != 0);
            tick();
            bad = ((bus.gateHi & bus.gateLo) != 3'b000);
`ifndef MOTORO3_BRAKE_EN
            bad = bad || ($countones(bus.gateLo) > 1);
`endif
            checks++;
            if (bad !== 1'b0) begin
                failures++;
                badCount++;
                if (badCount <= 10)
                    $display("FAIL overlap cycle %0d: gateHi=%b gateLo=%b required disjoint", i, bus.gateHi, bus.gateLo);
            end
        end
        bus.m3cntLast1 = 0;
        bus.m3r_enable = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_enable();
        test_step_change();
        test_deadzero_pwm();
        test_fault();
        test_dead_restart();
        test_brake();
        test_async_reset();
        test_random_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
